// File: rtl/controlador_elevador.sv
// SCAN elevator controller: reads the request store at the current floor, moves the car, clears served requests.
// Latency: CICLOS_VIAGEM+1 cycles per floor, 1+1+CICLOS_PORTA to serve the current floor; no backpressure, all outputs decoded from registered state.
module controlador_elevador #(
    parameter int CICLOS_VIAGEM = 4,
    parameter int CICLOS_PORTA  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       terreo,
    input  logic       primeiro_andar,
    input  logic       segundo_andar,
    input  logic       terceiro_andar,
    input  logic       saida_endereco,
    output logic [1:0] endereco,
    output logic       escrita,
    output logic       dado,
    output logic       motor_subir,
    output logic       motor_descer,
    output logic       porta_aberta,
    output logic       direcao
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        MOVENDO = 3'd1,
        CHEGADA = 3'd2,
        LIMPAR  = 3'd3,
        PORTA   = 3'd4
    } estado_t;

    localparam logic [7:0] VIAGEM_FIM = 8'(CICLOS_VIAGEM - 1);
    localparam logic [7:0] PORTA_FIM  = 8'(CICLOS_PORTA - 1);

    estado_t    estado_q, estado_d;
    logic [1:0] endereco_q, endereco_d;
    logic       direcao_q, direcao_d;
    logic [7:0] timer_q, timer_d;

    logic [3:0] pedidos;
    logic [3:0] mascara_acima;
    logic [3:0] mascara_abaixo;
    logic       acima;
    logic       abaixo;
    logic       a_frente;
    logic       atras;

    assign pedidos        = {terceiro_andar, segundo_andar, primeiro_andar, terreo};
    // Shifting past bit 3 drops out of the 4-bit mask, so floor 3 sees nothing above.
    assign mascara_acima  = 4'b1110 << endereco_q;
    assign mascara_abaixo = ~(4'b1111 << endereco_q);
    assign acima          = |(pedidos & mascara_acima);
    assign abaixo         = |(pedidos & mascara_abaixo);
    assign a_frente       = direcao_q ? acima  : abaixo;
    assign atras          = direcao_q ? abaixo : acima;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            endereco_q <= 2'd0;
            direcao_q  <= 1'b1;
            timer_q    <= 8'd0;
        end else begin
            estado_q   <= estado_d;
            endereco_q <= endereco_d;
            direcao_q  <= direcao_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        endereco_d = endereco_q;
        direcao_d  = direcao_q;
        timer_d    = timer_q;
        case (estado_q)
            OCIOSO, CHEGADA: begin
                if (saida_endereco) begin
                    estado_d = LIMPAR;
                end else if (a_frente) begin
                    estado_d = MOVENDO;
                end else if (atras) begin
                    direcao_d = ~direcao_q;
                    estado_d  = MOVENDO;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            MOVENDO: begin
                if (timer_q == VIAGEM_FIM) begin
                    timer_d    = 8'd0;
                    endereco_d = direcao_q ? endereco_q + 2'd1 : endereco_q - 2'd1;
                    estado_d   = CHEGADA;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            LIMPAR: begin
                timer_d  = 8'd0;
                estado_d = PORTA;
            end
            PORTA: begin
                if (timer_q == PORTA_FIM) begin
                    timer_d  = 8'd0;
                    estado_d = OCIOSO;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: begin
                timer_d  = 8'd0;
                estado_d = OCIOSO;
            end
        endcase
    end

    always_comb begin
        endereco     = endereco_q;
        direcao      = direcao_q;
        escrita      = (estado_q == LIMPAR);
        dado         = 1'b0;
        motor_subir  = (estado_q == MOVENDO) &&  direcao_q;
        motor_descer = (estado_q == MOVENDO) && !direcao_q;
        porta_aberta = (estado_q == PORTA);
    end

endmodule

// File: doc/controlador_elevador.md
# controlador_elevador

Elevator car controller that consumes the floor-request store: it reads the four latched requests in parallel and at the current floor, moves the car with SCAN (keep direction while requests remain ahead), and clears each served request by writing 0 back into the store. It sits between the request memory (as the store's only reader/clearer) and the motor/door drivers, and owns the address bus into the store.

## Interface

Parameters:
- CICLOS_VIAGEM, 4: clock cycles the motor is driven to travel one floor (1..255).
- CICLOS_PORTA, 3: clock cycles the door stays open at a served floor (1..255).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock and reset is asynchronous and active-high
- terreo, primeiro_andar, segundo_andar, terceiro_andar  in  1 each  parallel request bits for floors 0..3 from the store
- saida_endereco  in  1  store read data for the floor on endereco (0 while escrita=1)
- endereco  out  2  current floor; also the store address
- escrita  out  1  store write strobe, one-cycle pulse
- dado  out  1  store write data, constant 0 (clear)
- motor_subir  out  1  drive car up
- motor_descer  out  1  drive car down
- porta_aberta  out  1  door open
- direcao  out  1  current scan direction, 1=up

## Operation

- States: OCIOSO, MOVENDO, CHEGADA, LIMPAR, PORTA.
- "acima" = any request bit with index > endereco; "abaixo" = any with index < endereco.
- OCIOSO: if saida_endereco=1 -> LIMPAR. Else if requests exist ahead in direcao -> MOVENDO. Else if requests exist in the opposite direction -> flip direcao, MOVENDO. Else stay.
- MOVENDO: motor_subir=direcao, motor_descer=~direcao; 8-bit timer counts; on the CICLOS_VIAGEM-th cycle endereco increments (up) or decrements (down), timer clears -> CHEGADA.
- CHEGADA: same decision as OCIOSO, except when no requests remain at all -> OCIOSO.
- LIMPAR: escrita=1, dado=0, endereco held, for exactly one cycle -> PORTA.
- PORTA: porta_aberta=1 for CICLOS_PORTA cycles -> OCIOSO.
- Motor outputs are 0 outside MOVENDO; motor_subir and motor_descer never both 1.
- endereco never leaves 0..3: movement is taken only when a request exists strictly beyond, so no wrap-around.
- Request at the current floor arriving during PORTA or LIMPAR: not re-cleared mid-state; OCIOSO picks it up next and reopens the door.
- Requests appearing or disappearing during MOVENDO do not abort the move; decision is re-made at CHEGADA.

## Timing

- Reset values: state OCIOSO, endereco=0, direcao=1, timer=0, escrita=0, dado=0, motor_subir=0, motor_descer=0, porta_aberta=0.
- Reset asserted mid-move or door-open: all outputs return to reset values immediately (asynchronous); car position is re-established as floor 0.
- All outputs registered or decoded from registered state only; no combinational path from request inputs to outputs.
- Per floor travelled: CICLOS_VIAGEM cycles MOVENDO + 1 cycle CHEGADA.
- Serve at current floor from OCIOSO: 1 cycle decision, 1 cycle LIMPAR, CICLOS_PORTA cycles PORTA.
- Request bit is expected to drop the cycle after the escrita pulse; controller does not wait for it.

## Test plan

- Reset mid-MOVENDO with endereco=2 -> all outputs 0, endereco=0, direcao=1 at once; no escrita pulse.
- Defaults, car at 0, set segundo_andar=1 at cycle 0 -> motor_subir cycles 1-4, CHEGADA endereco=1 cycle 5, motor_subir cycles 6-9, endereco=2 cycle 10, escrita=1/dado=0/endereco=2 cycle 11, porta_aberta cycles 12-14, OCIOSO cycle 15.
- Car at 0, terreo=1 -> escrita pulse at endereco=0 in cycle 1, porta_aberta 3 cycles, no motor activity.
- Car at 1 going up, requests at 0 and 3 -> serves 3 first (direcao stays 1), then flips direcao=0 and serves 0; exactly two escrita pulses, at endereco 3 then 0.
- Car at 2, request at 1 and 3 set while car is in MOVENDO toward 2 (up) -> continues to 3 first, then 1.
- No requests for 100 cycles -> stays OCIOSO, all outputs constant at reset values, endereco unchanged.
